// File: rtl/adder_tree_pkg.sv
// Shared helpers for the popcount adder-tree family: width and depth
// calculations plus a per-level valid vector type.
package adder_tree_pkg;

  // Deepest tree any variant is expected to build (2^16 leaves).
  localparam int MAX_TREE_LEVELS = 16;

  // One valid bit per pipeline level, leaf stage included.
  typedef logic [MAX_TREE_LEVELS:0] level_valid_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Adder levels needed to reduce 'leaves' partial counts to one.
  function automatic int tree_levels(input int leaves);
    return (leaves <= 1) ? 0 : $clog2(leaves);
  endfunction

  // Node count at a given tree level (level 0 = leaves), ceil-halving each level.
  function automatic int level_nodes(input int leaves, input int lvl);
    return (leaves + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/popcount_leaf.sv
// Combinational popcount of one LEAF_WIDTH-bit slice of the input vector.
module popcount_leaf
  import adder_tree_pkg::*;
#(
  parameter int LEAF_WIDTH = 8,
  localparam int CNT_W = popcount_width(LEAF_WIDTH)
) (
  input  logic [LEAF_WIDTH-1:0] bits,
  output logic [CNT_W-1:0]      count
);

  // Sum the individual bits of the slice.
  always_comb begin
    count = '0;
    for (int k = 0; k < LEAF_WIDTH; k++) begin
      count = count + CNT_W'(bits[k]);
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined, backpressured popcount with an optional window accumulator.
// Leaf counts are registered, then LEVELS registered pairwise-add stages,
// then one accumulator stage that folds WINDOW accepted beats into a result.
// The whole pipe stalls as one unit while a result waits on out_ready.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS = 200,
  parameter int LEAF_WIDTH = 8,
  parameter int WINDOW     = 1,
  localparam int NUM_LEAVES = (NUM_INPUTS + LEAF_WIDTH - 1) / LEAF_WIDTH,
  localparam int LEVELS     = tree_levels(NUM_LEAVES),
  localparam int SUM_WIDTH  = popcount_width(NUM_INPUTS),
  localparam int ACC_WIDTH  = popcount_width(NUM_INPUTS * WINDOW),
  localparam int BEAT_W     = popcount_width(WINDOW)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_INPUTS-1:0] inputs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic [BEAT_W-1:0]     beat_cnt
);

  localparam int LEAF_CNT_W = popcount_width(LEAF_WIDTH);
  // Every level is stored at the widest width it could need; the tree value
  // never exceeds NUM_INPUTS, so the add at each level cannot overflow.
  localparam int TREE_W     = LEAF_CNT_W + LEVELS;
  localparam int PADDED_W   = NUM_LEAVES * LEAF_WIDTH;

  logic                  advance_s;
  logic                  accept_s;
  logic [PADDED_W-1:0]   padded_s;
  logic [LEAF_CNT_W-1:0] leaf_cnt_s [NUM_LEAVES];
  logic [TREE_W-1:0]     node_d [LEVELS+1][NUM_LEAVES];
  logic [TREE_W-1:0]     node_q [LEVELS+1][NUM_LEAVES];
  logic [LEVELS:0]       vld_d, vld_q;
  logic [SUM_WIDTH-1:0]  tree_res_s;
  logic                  tree_vld_s;
  logic [ACC_WIDTH-1:0]  acc_d, acc_q;
  logic [ACC_WIDTH-1:0]  acc_next_s;
  logic [ACC_WIDTH-1:0]  sum_d, sum_q;
  logic [BEAT_W-1:0]     beat_d, beat_q;
  logic                  out_valid_d, out_valid_q;

  // Pipe moves unless a completed result is being held for downstream.
  assign advance_s = !(out_valid_q && !out_ready);
  assign in_ready  = advance_s && !clear;
  assign accept_s  = in_valid && in_ready;

  // Zero-pad the input vector out to a whole number of leaves.
  always_comb begin
    padded_s                   = '0;
    padded_s[NUM_INPUTS-1:0]   = inputs;
  end

  genvar l, i;
  for (i = 0; i < NUM_LEAVES; i++) begin : g_leaf
    popcount_leaf #(.LEAF_WIDTH(LEAF_WIDTH)) u_leaf (
      .bits  (padded_s[i*LEAF_WIDTH +: LEAF_WIDTH]),
      .count (leaf_cnt_s[i])
    );
  end

  // Next value of every tree node; unused slots of a level are tied to zero
  // and an odd node at the end of a level passes straight through.
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    for (i = 0; i < NUM_LEAVES; i++) begin : g_node
      if (i >= level_nodes(NUM_LEAVES, l)) begin : g_unused
        assign node_d[l][i] = '0;
      end else if (l == 0) begin : g_leaf_in
        assign node_d[l][i] = TREE_W'(leaf_cnt_s[i]);
      end else begin : g_add
        if (2*i + 1 < level_nodes(NUM_LEAVES, l - 1)) begin : g_pair
          assign node_d[l][i] = node_q[l-1][2*i] + node_q[l-1][2*i+1];
        end else begin : g_pass
          assign node_d[l][i] = node_q[l-1][2*i];
        end
      end
    end
  end

  // Tree data registers move together whenever the pipe advances.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int lv = 0; lv <= LEVELS; lv++) begin
        for (int n = 0; n < NUM_LEAVES; n++) begin
          node_q[lv][n] <= '0;
        end
      end
    end else if (advance_s) begin
      node_q <= node_d;
    end
  end

  // Per-stage valid bits: shift on advance, flush on clear, hold on stall.
  always_comb begin
    vld_d = vld_q;
    if (clear) begin
      vld_d = '0;
    end else if (advance_s) begin
      vld_d[0] = accept_s;
      for (int lv = 1; lv <= LEVELS; lv++) begin
        vld_d[lv] = vld_q[lv-1];
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Stage valid registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign tree_vld_s = vld_q[LEVELS];
  assign tree_res_s = SUM_WIDTH'(node_q[LEVELS][0]);
  assign acc_next_s = acc_q + ACC_WIDTH'(tree_res_s);

  // Window accumulator and output holding register.
  always_comb begin
    acc_d       = acc_q;
    beat_d      = beat_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      acc_d       = '0;
      beat_d      = '0;
      out_valid_d = 1'b0;
    end else if (advance_s) begin
      // Advancing means any held result has just been taken.
      out_valid_d = 1'b0;
      if (tree_vld_s) begin
        if (beat_q == BEAT_W'(WINDOW - 1)) begin
          sum_d       = acc_next_s;
          out_valid_d = 1'b1;
          acc_d       = '0;
          beat_d      = '0;
        end else begin
          acc_d  = acc_next_s;
          beat_d = beat_q + BEAT_W'(1);
        end
      end else begin
        acc_d  = acc_q;
        beat_d = beat_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Accumulator stage registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q       <= '0;
      beat_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench: DUT A (200 inputs, per-beat popcount) and DUT B
// (13 inputs, 4-beat window). Expected sums are pushed at accept time from
// a plain popcount/window model; monitors pop and compare on each transfer.
module tb_pipelined_adder_tree;

  localparam int LAT_A = 7;

  typedef struct {
    int sum;
    int cyc;
  } exp_t;

  logic         clk;
  logic         nRST;
  int           cyc;
  int           checks;
  int           failures;
  bit           lat_chk;
  bit           rnd_on;

  logic         a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [199:0] a_inputs;
  logic [7:0]   a_sum;
  logic [0:0]   a_beat_cnt;

  logic         b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [12:0]  b_inputs;
  logic [5:0]   b_sum;
  logic [2:0]   b_beat_cnt;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   b_win_acc;
  int   b_win_n;

  bit          a_prev_stall, b_prev_stall;
  logic [7:0]  a_prev_sum;
  logic [5:0]  b_prev_sum;

  pipelined_adder_tree #(.NUM_INPUTS(200), .LEAF_WIDTH(8), .WINDOW(1)) u_dut_a (
    .CLK(clk), .nRST(nRST), .clear(a_clear), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .inputs(a_inputs), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sum(a_sum), .beat_cnt(a_beat_cnt)
  );

  pipelined_adder_tree #(.NUM_INPUTS(13), .LEAF_WIDTH(8), .WINDOW(4)) u_dut_b (
    .CLK(clk), .nRST(nRST), .clear(b_clear), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .inputs(b_inputs), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum(b_sum), .beat_cnt(b_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [199:0] rand_a();
    logic [223:0] t, u;
    for (int k = 0; k < 7; k++) begin
      t[k*32 +: 32] = $urandom();
      u[k*32 +: 32] = $urandom();
    end
    case ($urandom_range(3))
      0: t = t & u;
      1: t = t | u;
      default: ;
    endcase
    return t[199:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat to DUT A; on acceptance record its popcount.
  task automatic a_beat(input logic [199:0] v);
    int n;
    exp_t e;
    a_inputs   = v;
    a_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_in_ready) begin
        e.sum = $countones(v);
        e.cyc = cyc;
        exp_a.push_back(e);
        break;
      end
      n++;
      if (n >= 200) begin
        chk("a_accept_wait", a_in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  // Offer one beat to DUT B; on acceptance fold it into the window model.
  task automatic b_beat(input logic [12:0] v);
    int n;
    exp_t e;
    b_inputs   = v;
    b_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (b_in_ready) begin
        b_win_acc += $countones(v);
        b_win_n++;
        if (b_win_n == 4) begin
          e.sum = b_win_acc;
          e.cyc = cyc;
          exp_b.push_back(e);
          b_win_acc = 0;
          b_win_n   = 0;
        end
        break;
      end
      n++;
      if (n >= 200) begin
        chk("b_accept_wait", b_in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  // One clear cycle on DUT B with a beat offered that must be refused.
  task automatic b_clear_cycle();
    b_clear    = 1'b1;
    b_in_valid = 1'b1;
    b_inputs   = 13'h1FFF;
    @(negedge clk);
    chk("b_clear_in_ready", b_in_ready, 0);
    @(posedge clk);
    exp_b.delete();
    b_win_acc = 0;
    b_win_n   = 0;
    #1;
    b_clear    = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Monitor for DUT A: handshake rule, hold-while-stalled, scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (!nRST) begin
      a_prev_stall = 1'b0;
    end else begin
      chk("a_in_ready_rule", a_in_ready, !(a_out_valid && !a_out_ready) && !a_clear);
      if (a_prev_stall) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_sum", a_sum, a_prev_sum);
      end
      if (a_out_valid && a_out_ready) begin
        chk("a_expected_avail", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          chk("a_sum", a_sum, e.sum);
          if (lat_chk) chk("a_latency", cyc - e.cyc, LAT_A);
        end
      end
      a_prev_stall = a_out_valid && !a_out_ready;
      a_prev_sum   = a_sum;
    end
  end

  // Monitor for DUT B.
  always @(negedge clk) begin
    exp_t e;
    if (!nRST) begin
      b_prev_stall = 1'b0;
    end else begin
      chk("b_in_ready_rule", b_in_ready, !(b_out_valid && !b_out_ready) && !b_clear);
      if (b_prev_stall) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_sum", b_sum, b_prev_sum);
      end
      if (b_out_valid && b_out_ready) begin
        chk("b_expected_avail", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          chk("b_sum", b_sum, e.sum);
        end
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      b_prev_sum   = b_sum;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; lat_chk = 1'b0; rnd_on = 1'b0;
    b_win_acc = 0; b_win_n = 0;
    nRST = 1'b0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_inputs = '0; a_out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_inputs = '0; b_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_sum", a_sum, 0);
    chk("rst_a_beat_cnt", a_beat_cnt, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_sum", b_sum, 0);
    chk("rst_b_beat_cnt", b_beat_cnt, 0);
    @(posedge clk); #1;
    nRST = 1'b1;
    #1;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_in_ready", b_in_ready, 1);
    idle(2);

    // Single all-ones beat, then 0 / all-ones / alternating back to back
    lat_chk = 1'b1;
    a_beat({200{1'b1}});
    idle(10);
    a_beat('0);
    a_beat({200{1'b1}});
    a_beat({100{2'b10}});
    idle(10);
    lat_chk = 1'b0;
    chk("a_drained_basic", exp_a.size(), 0);

    // Five-cycle out_ready stall with a stream behind it
    fork
      begin
        for (int k = 0; k < 12; k++) a_beat(rand_a());
      end
      begin
        idle(9);
        a_out_ready = 1'b0;
        idle(5);
        a_out_ready = 1'b1;
      end
    join
    idle(10);
    chk("a_drained_stall", exp_a.size(), 0);

    // Random stream with random bubbles and backpressure
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          if ($urandom_range(3) == 0) idle(1);
          a_beat(rand_a());
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          idle(1);
          a_out_ready = ($urandom_range(2) != 0);
        end
      end
    join
    a_out_ready = 1'b1;
    idle(12);
    chk("a_drained_random", exp_a.size(), 0);

    // Window of four: popcounts 13, 0, 5, 13
    b_beat(13'h1FFF);
    b_beat(13'h0000);
    b_beat(13'h001F);
    b_beat(13'h1FFF);
    idle(8);
    chk("b_beat_cnt_after_window", b_beat_cnt, 0);
    chk("b_drained_window", exp_b.size(), 0);

    // Partial window discarded by clear, then four beats of three ones
    b_beat(13'(($urandom_range(8191))));
    b_beat(13'(($urandom_range(8191))));
    idle(6);
    chk("b_beat_cnt_partial", b_beat_cnt, 2);
    chk("b_no_out_partial", b_out_valid, 0);
    b_clear_cycle();
    chk("b_beat_cnt_cleared", b_beat_cnt, 0);
    chk("b_out_valid_cleared", b_out_valid, 0);
    for (int k = 0; k < 4; k++) b_beat(13'(13'h7 << $urandom_range(10)));
    idle(8);
    chk("b_drained_clear", exp_b.size(), 0);

    // Random windowed stream with backpressure
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          if ($urandom_range(3) == 0) idle(1);
          b_beat(13'($urandom_range(8191)));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          idle(1);
          b_out_ready = ($urandom_range(2) != 0);
        end
      end
    join
    b_out_ready = 1'b1;
    idle(8);
    chk("b_drained_random", exp_b.size(), b_win_n == 0 ? 0 : 0);
    chk("b_beat_cnt_random", b_beat_cnt, b_win_n);

    // Asynchronous reset pulse in the middle of a DUT A stream
    for (int k = 0; k < 10; k++) a_beat(rand_a());
    #1;
    nRST       = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("arst_a_out_valid", a_out_valid, 0);
    chk("arst_a_sum", a_sum, 0);
    chk("arst_a_beat_cnt", a_beat_cnt, 0);
    chk("arst_b_beat_cnt", b_beat_cnt, 0);
    exp_a.delete();
    exp_b.delete();
    b_win_acc = 0;
    b_win_n   = 0;
    @(posedge clk); #3;
    nRST = 1'b1;
    idle(1);
    for (int k = 0; k < 10; k++) a_beat(rand_a());
    idle(12);
    chk("a_drained_after_reset", exp_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
